// File: rtl/aes_trace_sequencer.sv
// Trace-acquisition sequencer: feeds AES_top fixed or LFSR-derived plaintexts, pulses the
// scope trigger per encryption, captures the first ciphertext of each trace and drives decoy data between traces.
module aes_trace_sequencer #(
  parameter int          DATA_W     = 128,
  parameter int          KEY_W      = 128,
  parameter int          NUM_TRACES = 16,
  parameter int          EN_HOLD    = 51,
  parameter int          GAP_CYCLES = 15,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_2468
) (
  input  logic              AES_clk,
  input  logic              AES_rst,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] fixed_data,
  input  logic [KEY_W-1:0]  key_cfg,
  output logic              AES_en,
  output logic [DATA_W-1:0] AES_data_in,
  output logic [KEY_W-1:0]  AES_key_in,
  input  logic              AES_data_out_valid,
  input  logic [DATA_W-1:0] AES_data_out,
  output logic              trig,
  output logic              cap_valid,
  output logic [DATA_W-1:0] cap_data,
  output logic [15:0]       trace_idx,
  output logic              busy,
  output logic              done,
  output logic [15:0]       miss_cnt
);

  localparam int CNT_MAX = (EN_HOLD > GAP_CYCLES) ? EN_HOLD : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(EN_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [15:0]      IDX_LAST = 16'(NUM_TRACES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_GAP,
    S_DONE
  } state_e;

  state_e              state_q;
  logic                mode_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                got_q;
  logic [31:0]         lfsr_q;
  logic [31:0]         lfsr_d;
  logic [DATA_W-1:0]   nz_q;
  logic [DATA_W-1:0]   nz_d;

  logic                en_q;
  logic [DATA_W-1:0]   data_in_q;
  logic [KEY_W-1:0]    key_in_q;
  logic                trig_q;
  logic                cap_valid_q;
  logic [DATA_W-1:0]   cap_data_q;
  logic [15:0]         trace_idx_q;
  logic                busy_q;
  logic                done_q;
  logic [15:0]         miss_q;

  // Taps 32, 22, 2, 1 of x^32+x^22+x^2+x+1, Fibonacci form.
  assign lfsr_d = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};

  generate
    if (DATA_W > 32) begin : g_nz_wide
      assign nz_d = {nz_q[DATA_W-33:0], lfsr_q};
    end else begin : g_nz_narrow
      assign nz_d = lfsr_q;
    end
  endgenerate

  always_ff @(posedge AES_clk) begin
    // NOTE: non-blocking assignments throughout, so every branch below reads pre-edge values.
    if (AES_rst) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      got_q       <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      nz_q        <= '0;
      en_q        <= 1'b0;
      data_in_q   <= '0;
      key_in_q    <= '0;
      trig_q      <= 1'b0;
      cap_valid_q <= 1'b0;
      cap_data_q  <= '0;
      trace_idx_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      miss_q      <= '0;
    end else begin
      trig_q      <= 1'b0;
      cap_valid_q <= 1'b0;
      done_q      <= 1'b0;

      // Noise source free-runs only while a run is in progress.
      if (state_q != S_IDLE) begin
        lfsr_q <= lfsr_d;
        nz_q   <= nz_d;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_q      <= mode;
            key_in_q    <= key_cfg;
            trace_idx_q <= '0;
            miss_q      <= '0;
            busy_q      <= 1'b1;
            state_q     <= S_LOAD;
          end
        end

        S_LOAD: begin
          data_in_q <= mode_q ? nz_q : fixed_data;
          en_q      <= 1'b1;
          trig_q    <= 1'b1;
          got_q     <= 1'b0;
          cnt_q     <= '0;
          state_q   <= S_RUN;
        end

        S_RUN: begin
          if (AES_data_out_valid && !got_q) begin
            cap_data_q  <= AES_data_out;
            cap_valid_q <= 1'b1;
            got_q       <= 1'b1;
          end
          if (cnt_q == RUN_LAST) begin
            en_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_GAP;
            // A valid on the final RUN cycle still counts as a hit.
            if (!got_q && !AES_data_out_valid && miss_q != 16'hFFFF) begin
              miss_q <= miss_q + 16'd1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_GAP: begin
          data_in_q <= nz_q;
          if (cnt_q == GAP_LAST) begin
            cnt_q <= '0;
            if (trace_idx_q == IDX_LAST) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              trace_idx_q <= trace_idx_q + 16'd1;
              state_q     <= S_LOAD;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_DONE: begin
          data_in_q <= '0;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign AES_en      = en_q;
  assign AES_data_in = data_in_q;
  assign AES_key_in  = key_in_q;
  assign trig        = trig_q;
  assign cap_valid   = cap_valid_q;
  assign cap_data    = cap_data_q;
  assign trace_idx   = trace_idx_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign miss_cnt    = miss_q;

endmodule

// File: tb/tb_aes_trace_sequencer.sv
// Bench for aes_trace_sequencer: AES_top stand-in with randomized response latency, a trace
// monitor, and a reference model computing plaintexts from the LFSR/noise rules by busy-cycle count.
module tb_aes_trace_sequencer;

  localparam int          DATA_W = 128;
  localparam int          KEY_W  = 128;
  localparam int          NUM    = 3;
  localparam int          EH     = 51;
  localparam int          GAP    = 15;
  localparam int          PER    = 1 + EH + GAP;
  localparam logic [31:0] SEED   = 32'hACE1_2468;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              mode = 1'b0;
  logic [DATA_W-1:0] fixed_data = '0;
  logic [KEY_W-1:0]  key_cfg = '0;
  logic              valid_in = 1'b0;
  logic [DATA_W-1:0] data_out = '0;

  logic              AES_en;
  logic [DATA_W-1:0] AES_data_in;
  logic [KEY_W-1:0]  AES_key_in;
  logic              trig;
  logic              cap_valid;
  logic [DATA_W-1:0] cap_data;
  logic [15:0]       trace_idx;
  logic              busy;
  logic              done;
  logic [15:0]       miss_cnt;

  always #5 clk = ~clk;

  aes_trace_sequencer #(
    .DATA_W(DATA_W), .KEY_W(KEY_W), .NUM_TRACES(NUM),
    .EN_HOLD(EH), .GAP_CYCLES(GAP), .LFSR_SEED(SEED)
  ) dut (
    .AES_clk(clk), .AES_rst(rst), .start(start), .mode(mode),
    .fixed_data(fixed_data), .key_cfg(key_cfg),
    .AES_en(AES_en), .AES_data_in(AES_data_in), .AES_key_in(AES_key_in),
    .AES_data_out_valid(valid_in), .AES_data_out(data_out),
    .trig(trig), .cap_valid(cap_valid), .cap_data(cap_data),
    .trace_idx(trace_idx), .busy(busy), .done(done), .miss_cnt(miss_cnt)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_model = 0;  // LFSR steps taken since the last reset

  always @(posedge clk) cyc++;

  // ---------------- reference model ----------------
  function automatic logic [31:0] lfsr_at(input int n);
    logic [31:0] l = SEED;
    for (int i = 0; i < n; i++) l = {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    return l;
  endfunction

  // Noise word w holds the LFSR value shifted in w steps before the latest one.
  function automatic logic [DATA_W-1:0] nz_at(input int n);
    logic [DATA_W-1:0] v = '0;
    for (int w = 0; w < DATA_W / 32; w++)
      if (n - 1 - w >= 0) v[32*w +: 32] = lfsr_at(n - 1 - w);
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] ciph(input logic [DATA_W-1:0] pt, input logic [KEY_W-1:0] k);
    logic [DATA_W-1:0] x = pt ^ k ^ {4{32'h5A5A_0F0F}};
    return {x[DATA_W-9:0], x[DATA_W-1:DATA_W-8]};
  endfunction

  // ---------------- AES_top stand-in ----------------
  bit   stub_on = 1'b0;
  int   lat_lo = 0, lat_hi = 0, lat2_off = -1;
  int   rcnt = -1, lat_cur = 0;
  logic en_prev = 1'b0;

  always @(negedge clk) begin
    if (AES_en === 1'b1 && en_prev !== 1'b1) begin
      rcnt = 0;
      lat_cur = $urandom_range(lat_hi, lat_lo);
    end else if (rcnt >= 0 && rcnt < 100000) begin
      rcnt++;
    end
    en_prev  = AES_en;
    valid_in = 1'b0;
    data_out = {$urandom, $urandom, $urandom, $urandom};
    if (stub_on && rcnt == lat_cur) begin
      valid_in = 1'b1;
      data_out = ciph(AES_data_in, AES_key_in);
    end else if (stub_on && lat2_off > 0 && rcnt == lat_cur + lat2_off) begin
      valid_in = 1'b1;
      data_out = ~ciph(AES_data_in, AES_key_in);
    end
  end

  // ---------------- monitor ----------------
  int                en_rise_q[$];
  int                trig_cyc_q[$];
  int                done_cyc_q[$];
  logic [DATA_W-1:0] pt_q[$];
  logic [DATA_W-1:0] cap_q[$];
  int                en_cycles = 0, gap_checks = 0, gap_same = 0, g = -1;
  logic              mon_en_prev = 1'b0;
  logic [DATA_W-1:0] prev_din = '0;

  always @(negedge clk) begin
    if (AES_en === 1'b1) begin
      en_cycles++;
      if (mon_en_prev !== 1'b1) en_rise_q.push_back(cyc);
      g = -1;
    end else if (mon_en_prev === 1'b1) begin
      g = 0;
    end else if (g >= 0) begin
      g++;
    end
    if (g >= 1 && g < GAP && busy === 1'b1) begin
      gap_checks++;
      if (AES_data_in === prev_din) gap_same++;
    end
    if (trig === 1'b1) begin
      trig_cyc_q.push_back(cyc);
      pt_q.push_back(AES_data_in);
    end
    if (cap_valid === 1'b1) cap_q.push_back(cap_data);
    if (done === 1'b1) done_cyc_q.push_back(cyc);
    mon_en_prev = AES_en;
    prev_din    = AES_data_in;
  end

  task automatic mon_clear();
    en_rise_q.delete(); trig_cyc_q.delete(); done_cyc_q.delete();
    pt_q.delete(); cap_q.delete();
    en_cycles = 0; gap_checks = 0; gap_same = 0; g = -1;
  endtask

  task automatic do_start(input logic m, output int t);
    @(posedge clk); #1;
    start = 1'b1; mode = m; t = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while (done_cyc_q.size() == 0 && i < budget) begin
      @(posedge clk); i++;
    end
    checks++;
    if (done_cyc_q.size() == 0) begin
      errors++; $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b1; mode = 1'b1;
    fixed_data = {$urandom, $urandom, $urandom, $urandom};
    key_cfg    = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++; if (AES_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b exp 0", AES_en); end
    checks++; if (AES_data_in !== '0) begin errors++; $display("FAIL reset_data_in: got %h exp 0", AES_data_in); end
    checks++; if (AES_key_in !== '0) begin errors++; $display("FAIL reset_key_in: got %h exp 0", AES_key_in); end
    checks++; if (trig !== 1'b0 || cap_valid !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: trig=%b cap_valid=%b done=%b exp 0", trig, cap_valid, done); end
    checks++; if (cap_data !== '0) begin errors++; $display("FAIL reset_cap_data: got %h exp 0", cap_data); end
    checks++; if (trace_idx !== 16'd0 || miss_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_counters: idx=%0d miss=%0d exp 0", trace_idx, miss_cnt); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_beats_start: busy=%b exp 0", busy); end
    n_model = 0;
  endtask

  task automatic test_mode0();
    int t;
    logic [DATA_W-1:0] fd1, fd2, exp_pt;
    logic [KEY_W-1:0]  key;
    mon_clear();
    stub_on = 1'b1; lat_lo = 0; lat_hi = EH - 1; lat2_off = -1;
    fd1 = 128'h000000b9_00000000_00000000_00000000;
    key = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
    fixed_data = fd1; key_cfg = key;
    do_start(1'b0, t);
    repeat (10) @(posedge clk);
    #1; fd2 = {$urandom, $urandom, $urandom, $urandom}; fixed_data = fd2;
    wait_done(NUM * PER + 20);
    checks++; if (en_rise_q.size() != NUM) begin errors++; $display("FAIL m0_en_rises: got %0d exp %0d", en_rise_q.size(), NUM); end
    else begin
      checks++; if (en_rise_q[0] != t + 2) begin errors++; $display("FAIL m0_en_latency: got %0d exp %0d", en_rise_q[0], t + 2); end
    end
    checks++; if (en_cycles != NUM * EH) begin errors++; $display("FAIL m0_en_cycles: got %0d exp %0d", en_cycles, NUM * EH); end
    checks++; if (trig_cyc_q.size() != NUM || cap_q.size() != NUM) begin
      errors++; $display("FAIL m0_counts: trig=%0d cap=%0d exp %0d", trig_cyc_q.size(), cap_q.size(), NUM); end
    else begin
      for (int j = 0; j < NUM; j++) begin
        exp_pt = (j == 0) ? fd1 : fd2;
        checks++; if (trig_cyc_q[j] != t + 2 + j * PER) begin
          errors++; $display("FAIL m0_trig_cycle[%0d]: got %0d exp %0d", j, trig_cyc_q[j], t + 2 + j * PER); end
        checks++; if (pt_q[j] !== exp_pt) begin errors++; $display("FAIL m0_pt[%0d]: got %h exp %h", j, pt_q[j], exp_pt); end
        checks++; if (cap_q[j] !== ciph(exp_pt, key)) begin
          errors++; $display("FAIL m0_cap[%0d]: got %h exp %h", j, cap_q[j], ciph(exp_pt, key)); end
      end
    end
    checks++; if (done_cyc_q.size() != 1 || done_cyc_q[0] != t + 1 + NUM * PER) begin
      errors++; $display("FAIL m0_done: count=%0d exp 1 at cycle %0d", done_cyc_q.size(), t + 1 + NUM * PER); end
    checks++; if (miss_cnt !== 16'd0) begin errors++; $display("FAIL m0_miss: got %0d exp 0", miss_cnt); end
    checks++; if (trace_idx !== 16'(NUM - 1)) begin errors++; $display("FAIL m0_trace_idx: got %0d exp %0d", trace_idx, NUM - 1); end
    checks++; if (AES_key_in !== key) begin errors++; $display("FAIL m0_key: got %h exp %h", AES_key_in, key); end
    checks++; if (busy !== 1'b0 || AES_data_in !== '0) begin
      errors++; $display("FAIL m0_idle: busy=%b data_in=%h exp 0", busy, AES_data_in); end
    n_model += NUM * PER + 1;
  endtask

  task automatic test_mode1();
    int t;
    logic [DATA_W-1:0] exp_pt;
    logic [KEY_W-1:0]  key;
    for (int r = 0; r < 2; r++) begin
      mon_clear();
      stub_on = 1'b1; lat_lo = 0; lat_hi = EH - 1; lat2_off = -1;
      key = {$urandom, $urandom, $urandom, $urandom}; key_cfg = key;
      do_start(1'b1, t);
      key_cfg = {$urandom, $urandom, $urandom, $urandom};
      wait_done(NUM * PER + 20);
      checks++; if (pt_q.size() != NUM || cap_q.size() != NUM) begin
        errors++; $display("FAIL m1_counts: pt=%0d cap=%0d exp %0d", pt_q.size(), cap_q.size(), NUM); end
      else begin
        for (int j = 0; j < NUM; j++) begin
          exp_pt = nz_at(n_model + j * PER);
          checks++; if (pt_q[j] !== exp_pt) begin errors++; $display("FAIL m1_pt[%0d]: got %h exp %h", j, pt_q[j], exp_pt); end
          checks++; if (cap_q[j] !== ciph(exp_pt, key)) begin
            errors++; $display("FAIL m1_cap[%0d]: got %h exp %h", j, cap_q[j], ciph(exp_pt, key)); end
          for (int k = 0; k < j; k++) begin
            checks++; if (pt_q[j] === pt_q[k]) begin errors++; $display("FAIL m1_distinct: pt[%0d]=pt[%0d]=%h", j, k, pt_q[j]); end
          end
        end
      end
      checks++; if (gap_checks != NUM * (GAP - 1) || gap_same != 0) begin
        errors++; $display("FAIL m1_gap_decoy: cycles=%0d stuck=%0d exp %0d and 0", gap_checks, gap_same, NUM * (GAP - 1)); end
      checks++; if (trace_idx !== 16'(NUM - 1)) begin errors++; $display("FAIL m1_trace_idx: got %0d exp %0d", trace_idx, NUM - 1); end
      checks++; if (AES_key_in !== key) begin errors++; $display("FAIL m1_key_latched: got %h exp %h", AES_key_in, key); end
      n_model += NUM * PER + 1;
    end
  endtask

  task automatic test_miss();
    int t;
    mon_clear();
    stub_on = 1'b0;
    do_start(1'b0, t);
    wait_done(NUM * PER + 20);
    checks++; if (miss_cnt !== 16'(NUM)) begin errors++; $display("FAIL miss_cnt: got %0d exp %0d", miss_cnt, NUM); end
    checks++; if (cap_q.size() != 0) begin errors++; $display("FAIL miss_no_cap: got %0d exp 0", cap_q.size()); end
    checks++; if (done_cyc_q.size() != 1) begin errors++; $display("FAIL miss_done: got %0d exp 1", done_cyc_q.size()); end
    n_model += NUM * PER + 1;
  endtask

  task automatic test_boundary();
    int t;
    // Valid on the first GAP cycle is too late and must be ignored.
    mon_clear();
    stub_on = 1'b1; lat_lo = EH; lat_hi = EH; lat2_off = -1;
    do_start(1'b0, t);
    wait_done(NUM * PER + 20);
    checks++; if (miss_cnt !== 16'(NUM) || cap_q.size() != 0) begin
      errors++; $display("FAIL gap_valid_ignored: miss=%0d caps=%0d exp %0d and 0", miss_cnt, cap_q.size(), NUM); end
    n_model += NUM * PER + 1;
    // Valid on the last RUN cycle is still a capture.
    mon_clear();
    lat_lo = EH - 1; lat_hi = EH - 1;
    fixed_data = {$urandom, $urandom, $urandom, $urandom};
    do_start(1'b0, t);
    wait_done(NUM * PER + 20);
    checks++; if (miss_cnt !== 16'd0 || cap_q.size() != NUM) begin
      errors++; $display("FAIL last_run_valid: miss=%0d caps=%0d exp 0 and %0d", miss_cnt, cap_q.size(), NUM); end
    else begin
      checks++; if (cap_q[NUM-1] !== ciph(fixed_data, AES_key_in)) begin
        errors++; $display("FAIL last_run_cap: got %h exp %h", cap_q[NUM-1], ciph(fixed_data, AES_key_in)); end
    end
    n_model += NUM * PER + 1;
  endtask

  task automatic test_back_to_back();
    int t;
    logic [KEY_W-1:0] key;
    mon_clear();
    stub_on = 1'b1; lat_lo = 0; lat_hi = 40; lat2_off = $urandom_range(10, 1);
    key = {$urandom, $urandom, $urandom, $urandom}; key_cfg = key;
    fixed_data = {$urandom, $urandom, $urandom, $urandom};
    do_start(1'b0, t);
    repeat (20) @(posedge clk);
    #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    while (cyc < t + 1 + NUM * PER) begin
      @(posedge clk); #1;
    end
    start = 1'b1;  // lands in the DONE cycle
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if (done_cyc_q.size() != 1 || en_rise_q.size() != NUM) begin
      errors++; $display("FAIL b2b_runs: done=%0d rises=%0d exp 1 and %0d", done_cyc_q.size(), en_rise_q.size(), NUM); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_not_requeued: busy=%b exp 0", busy); end
    checks++; if (cap_q.size() != NUM) begin errors++; $display("FAIL b2b_one_capture: got %0d exp %0d", cap_q.size(), NUM); end
    else begin
      for (int j = 0; j < NUM; j++) begin
        checks++; if (cap_q[j] !== ciph(fixed_data, key)) begin
          errors++; $display("FAIL b2b_first_valid[%0d]: got %h exp %h", j, cap_q[j], ciph(fixed_data, key)); end
      end
    end
    n_model += NUM * PER + 1;
  endtask

  task automatic test_reset_mid_run();
    int t, i;
    logic [DATA_W-1:0] exp_pt;
    logic [KEY_W-1:0]  key;
    mon_clear();
    stub_on = 1'b1; lat_lo = 0; lat_hi = 20; lat2_off = -1;
    do_start(1'b1, t);
    i = 0;
    while (trig_cyc_q.size() < 2 && i < 2 * PER + 10) begin
      @(posedge clk); i++;
    end
    checks++; if (trig_cyc_q.size() < 2) begin errors++; $display("FAIL rst_mid_reach: trigs=%0d exp 2", trig_cyc_q.size()); end
    repeat (25) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || AES_en !== 1'b0) begin
      errors++; $display("FAIL rst_mid_idle: busy=%b en=%b exp 0", busy, AES_en); end
    checks++; if (cap_data !== '0 || trace_idx !== 16'd0 || AES_data_in !== '0) begin
      errors++; $display("FAIL rst_mid_clear: cap=%h idx=%0d din=%h exp 0", cap_data, trace_idx, AES_data_in); end
    n_model = 0;
    mon_clear();
    repeat (NUM * PER) @(posedge clk);
    checks++; if (done_cyc_q.size() != 0 || en_rise_q.size() != 0) begin
      errors++; $display("FAIL rst_mid_quiet: done=%0d rises=%0d exp 0", done_cyc_q.size(), en_rise_q.size()); end
    mon_clear();
    key = {$urandom, $urandom, $urandom, $urandom}; key_cfg = key;
    lat_hi = EH - 1;
    do_start(1'b1, t);
    wait_done(NUM * PER + 20);
    checks++; if (trig_cyc_q.size() != NUM || cap_q.size() != NUM) begin
      errors++; $display("FAIL rerun_counts: trig=%0d cap=%0d exp %0d", trig_cyc_q.size(), cap_q.size(), NUM); end
    else begin
      checks++; if (trig_cyc_q[0] != t + 2) begin errors++; $display("FAIL rerun_latency: got %0d exp %0d", trig_cyc_q[0], t + 2); end
      for (int j = 0; j < NUM; j++) begin
        exp_pt = nz_at(j * PER);
        checks++; if (pt_q[j] !== exp_pt) begin errors++; $display("FAIL rerun_pt[%0d]: got %h exp %h", j, pt_q[j], exp_pt); end
        checks++; if (cap_q[j] !== ciph(exp_pt, key)) begin
          errors++; $display("FAIL rerun_cap[%0d]: got %h exp %h", j, cap_q[j], ciph(exp_pt, key)); end
      end
    end
    checks++; if (trace_idx !== 16'(NUM - 1) || miss_cnt !== 16'd0) begin
      errors++; $display("FAIL rerun_final: idx=%0d miss=%0d exp %0d and 0", trace_idx, miss_cnt, NUM - 1); end
    n_model += NUM * PER + 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mode0();
    test_mode1();
    test_miss();
    test_boundary();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
